// File: rtl/decoder_4to16_pulse.sv
// Accepts a 4-bit code and drives the matching one-hot bit of y for PULSE_LEN cycles.
// Optional macro DEC_GAP_EN inserts a one-cycle GAP state after each pulse.
//
// state  | meaning
// IDLE   | waiting for in_valid; in_ready high unless clr
// ACTIVE | y holds the one-hot code while the counter runs down to 0
// GAP    | (DEC_GAP_EN only) one dead cycle after a pulse, y=0, not ready
module decoder_4to16_pulse #(
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [3:0]  in_code,
    output logic        in_ready,
    output logic [15:0] y,
    output logic        y_valid,
    output logic        busy,
    output logic        done
);

`ifdef DEC_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1} state_t;
`endif

    localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);

    state_t     state;
    logic [7:0] cnt;

    assign in_ready = (state == IDLE) && !clr;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            y       <= 16'h0000;
            y_valid <= 1'b0;
            done    <= 1'b0;
        end else if (clr) begin
            // abort beats acceptance and completion alike, so no done here
            state   <= IDLE;
            cnt     <= 8'd0;
            y       <= 16'h0000;
            y_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y       <= 16'h0001 << in_code;
                        y_valid <= 1'b1;
                        cnt     <= CNT_LOAD;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cnt == 8'd0) begin
                        y       <= 16'h0000;
                        y_valid <= 1'b0;
                        done    <= 1'b1;
`ifdef DEC_GAP_EN
                        state   <= GAP;
`else
                        state   <= IDLE;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`ifdef DEC_GAP_EN
                GAP: begin
                    state <= IDLE;
                end
`endif
                default: begin
                    state   <= IDLE;
                    cnt     <= 8'd0;
                    y       <= 16'h0000;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_4to16_pulse.sv
// Scoreboard bench for decoder_4to16_pulse: a cycle model pushes expected outputs
// as stimulus is driven; they are popped and compared one edge later.
module tb_decoder_4to16_pulse;

    localparam int P = 4;
`ifdef DEC_GAP_EN
    localparam int GAP_CYC = 1;
`else
    localparam int GAP_CYC = 0;
`endif
    localparam int PERIOD = P + 1 + GAP_CYC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, in_valid;
    logic [3:0]  in_code;
    logic        in_ready, y_valid, busy, done;
    logic [15:0] y;

    logic        clr1, in_valid1;
    logic [3:0]  in_code1;
    logic        in_ready1, y_valid1, busy1, done1;
    logic [15:0] y1;

    always #5 clk = ~clk;

    decoder_4to16_pulse #(.PULSE_LEN(P)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .y(y), .y_valid(y_valid), .busy(busy), .done(done)
    );

    decoder_4to16_pulse #(.PULSE_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .in_valid(in_valid1), .in_code(in_code1),
        .in_ready(in_ready1), .y(y1), .y_valid(y_valid1), .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic [15:0] y;
        logic        yv;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    int          m_state, m_cnt;
    logic [15:0] m_y;
    logic        m_yv, m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_y = 16'h0; m_yv = 1'b0; m_done = 1'b0;
    endtask

    // drive one cycle of stimulus, predict, then compare after the edge
    task automatic step(input logic c, input logic v, input logic [3:0] code);
        exp_t e;
        clr = c; in_valid = v; in_code = code;
        #1;
        chk("in_ready", 32'(in_ready), 32'((m_state == 0) && !c));
        if (c) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            case (m_state)
                0: if (v) begin
                    m_y = 16'd1 << code; m_yv = 1'b1; m_cnt = P - 1; m_state = 1;
                end
                1: if (m_cnt == 0) begin
                    m_y = 16'h0; m_yv = 1'b0; m_done = 1'b1;
                    m_state = (GAP_CYC != 0) ? 2 : 0;
                end else begin
                    m_cnt--;
                end
                default: m_state = 0;
            endcase
        end
        sb.push_back('{y: m_y, yv: m_yv, busy: (m_state != 0), done: m_done});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("y", 32'(y), 32'(e.y));
        chk("y_valid", 32'(y_valid), 32'(e.yv));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("onehot", 32'($countones(y) <= 1), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_code = 4'h0;
        clr1 = 1'b0; in_valid1 = 1'b0; in_code1 = 4'h0;
        model_reset();
        #1;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single pulse of code A
        step(1'b0, 1'b1, 4'hA);
        chk("a_y_c1", 32'(y), 32'h0400);
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 1'b0, 4'h0);
            chk("a_y_hold", 32'(y), 32'h0400);
        end
        step(1'b0, 1'b0, 4'h0);
        chk("a_done_c5", 32'(done), 32'd1);
        chk("a_y_c5", 32'(y), 32'h0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'h0);

        // back-to-back sweep with in_valid held high
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < PERIOD; j++) begin
                step(1'b0, 1'b1, 4'(k));
                if (j == 0) chk("sweep_y", 32'(y), 32'(16'd1 << k));
            end
        end
        for (int i = 0; i < PERIOD; i++) step(1'b0, 1'b0, 4'h0);

        // clr on cycle 2 of a code-F pulse
        step(1'b0, 1'b1, 4'hF);
        step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        chk("clr_y", 32'(y), 32'h0);
        step(1'b0, 1'b0, 4'h0);

        // clr coincides with terminal count
        step(1'b0, 1'b1, 4'h9);
        for (int i = 0; i < P - 1; i++) step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        chk("clr_tc_done", 32'(done), 32'd0);
        step(1'b0, 1'b0, 4'h0);

        // clr and in_valid together in IDLE
        step(1'b1, 1'b1, 4'h7);
        chk("clr_vld_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b0, 4'h0);

        // reset mid-pulse
        step(1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b0, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_y", 32'(y), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        model_reset();
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 4'h5);
        chk("post_rst_y", 32'(y), 32'h0020);
        for (int i = 0; i < PERIOD; i++) step(1'b0, 1'b0, 4'h0);

        // PULSE_LEN=1 instance
        in_valid1 = 1'b1; in_code1 = 4'h0;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("p1_y", 32'(y1), 32'h0001);
        chk("p1_y_valid", 32'(y_valid1), 32'd1);
        chk("p1_done_early", 32'(done1), 32'd0);
        @(posedge clk); #1;
        chk("p1_y_off", 32'(y1), 32'h0);
        chk("p1_done", 32'(done1), 32'd1);
        @(posedge clk); #1;
        chk("p1_done_pulse", 32'(done1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
